serial_signed_comparator: RTL and testbench



---
 rtl/cmp_pkg.sv | 21 ++
 rtl/cmp_bit_cell.sv | 21 ++
 rtl/serial_signed_comparator.sv | 128 ++++++++++++
 tb/tb_serial_signed_comparator.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the bit-serial signed comparator.
// Holds the FSM state encoding, one-hot result codes and index-width helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot {g, l, e} result codes; RES_NONE is driven whenever no result is offered.
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  function automatic int idx_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// Single-bit decision cell for the serial comparator.
// Raises set_gt/set_lt on the first differing bit; the sign bit has inverted weight.
module cmp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic is_sign,
  input  logic decided,
  output logic set_gt,
  output logic set_lt
);

  logic a_only;
  logic b_only;

  assign a_only = a_bit & ~b_bit;
  assign b_only = ~a_bit & b_bit;

  assign set_gt = ~decided & (is_sign ? b_only : a_only);
  assign set_lt = ~decided & (is_sign ? a_only : b_only);

endmodule

// File: rtl/serial_signed_comparator.sv
// Bit-serial two's-complement comparator with valid/ready operand and result channels.
// Optional macro CMP_EARLY_EXIT_EN ends the scan on the first differing bit.
module serial_signed_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             g,
  output logic             l,
  output logic             e,
  output logic             busy
);

  localparam int            IW      = idx_width(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             gt_q;
  logic             lt_q;
  logic             set_gt;
  logic             set_lt;
  logic             is_sign;
  logic             scan_end;
  logic [2:0]       res;

  assign is_sign = (idx == IDX_MSB);

  cmp_bit_cell u_cell (
    .a_bit   (a_q[idx]),
    .b_bit   (b_q[idx]),
    .is_sign (is_sign),
    .decided (gt_q | lt_q),
    .set_gt  (set_gt),
    .set_lt  (set_lt)
  );

`ifdef CMP_EARLY_EXIT_EN
  assign scan_end = (idx == '0) || set_gt || set_lt;
`else
  assign scan_end = (idx == '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands are only sampled on the accepting edge, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q <= a;
      b_q <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx  <= IDX_MSB;
      gt_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            idx  <= IDX_MSB;
            gt_q <= 1'b0;
            lt_q <= 1'b0;
          end
        end
        SCAN: begin
          gt_q <= gt_q | set_gt;
          lt_q <= lt_q | set_lt;
          if (idx != '0) begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SCAN;
      SCAN:    if (scan_end)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    res       = RES_NONE;
    if (state == DONE) begin
      if (gt_q) begin
        res = RES_GT;
      end else if (lt_q) begin
        res = RES_LT;
      end else begin
        res = RES_EQ;
      end
    end
  end

  assign g = res[2];
  assign l = res[1];
  assign e = res[0];

endmodule

// File: tb/tb_serial_signed_comparator.sv
// Self-checking bench for serial_signed_comparator: directed table, corner sequences,
// random pairs and a streaming run, against a signed-arithmetic reference model.
module tb_serial_signed_comparator;

  localparam int WIDTH = 16;
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             in_ready;
  logic             out_valid;
  logic             g;
  logic             l;
  logic             e;
  logic             busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic [2:0]       exp_gle;
    int               lat_fixed;
    int               lat_early;
  } vec_t;

  vec_t vecs [9];

  serial_signed_comparator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .g         (g),
    .l         (l),
    .e         (e),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] simulation timeout");
  end

  function automatic logic [2:0] ref_gle(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if ($signed(x) > $signed(y)) return 3'b100;
    if ($signed(x) < $signed(y)) return 3'b010;
    return 3'b001;
  endfunction

  // Early exit finishes on the most significant differing bit k, i.e. after WIDTH-k cycles.
  function automatic int ref_latency(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int lat = WIDTH;
    if (EARLY) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (x[i] != y[i]) lat = WIDTH - i;
      end
    end
    return lat;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("in_ready_before_accept", in_ready, 1);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    checkOutput("in_ready_after_accept", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("out_valid_after_handshake", out_valid, 0);
    checkOutput("gle_after_handshake", {g, l, e}, 3'b000);
    checkOutput("in_ready_after_handshake", in_ready, 1);
  endtask

  task automatic runVector(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic [2:0] exp_gle, input int exp_lat);
    int lat;
    applyStimulus(x, y, lat);
    checkOutput({name, "_latency"}, lat, exp_lat);
    checkOutput({name, "_gle"}, {g, l, e}, exp_gle);
    checkOutput({name, "_busy"}, busy, 1);
    releaseResult();
  endtask

  initial begin
    int         lat;
    int         stale;
    int         sent;
    int         recv;
    int         cyc;
    int         last_acc;
    bit         accepted;
    logic [2:0] expv;
    logic [2:0] held;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] pa [4];
    logic [WIDTH-1:0] pb [4];
    logic [2:0]       expq [$];

    vecs[0] = '{16'h0005, 16'h0003, 3'b100, 16, 14};
    vecs[1] = '{16'hFFFF, 16'h0001, 3'b010, 16, 1};
    vecs[2] = '{16'h7FFF, 16'h8000, 3'b100, 16, 1};
    vecs[3] = '{16'h8000, 16'h8000, 3'b001, 16, 16};
    vecs[4] = '{16'h0000, 16'hFFFF, 3'b100, 16, 1};
    vecs[5] = '{16'h1234, 16'h1235, 3'b010, 16, 16};
    vecs[6] = '{16'hFFFE, 16'hFFFF, 3'b010, 16, 16};
    vecs[7] = '{16'h8000, 16'h7FFF, 3'b010, 16, 1};
    vecs[8] = '{16'h0100, 16'h00FF, 3'b100, 16, 8};

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_gle", {g, l, e}, 3'b000);
    checkOutput("reset_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed table");
    for (int i = 0; i < 9; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].exp_gle,
                EARLY ? vecs[i].lat_early : vecs[i].lat_fixed);
    end

    $display("[TB] random pairs");
    for (int i = 0; i < 20; i++) begin
      x = WIDTH'($urandom);
      y = ($urandom_range(0, 3) == 0) ? x : WIDTH'($urandom);
      runVector($sformatf("rand%0d", i), x, y, ref_gle(x, y), ref_latency(x, y));
    end

    $display("[TB] result backpressure");
    applyStimulus(16'h0005, 16'h0003, lat);
    checkOutput("bp_gle", {g, l, e}, 3'b100);
    held = {g, l, e};
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      @(posedge clk); #1;
      checkOutput("bp_out_valid_held", out_valid, 1);
      checkOutput("bp_gle_held", {g, l, e}, held);
      checkOutput("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    releaseResult();
    @(posedge clk); #1;
    checkOutput("bp_no_ghost_accept", busy, 0);

    $display("[TB] reset during scan");
    a        = 16'h1234;
    b        = 16'h1234;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    checkOutput("scan_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("midreset_in_ready", in_ready, 1);
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_gle", {g, l, e}, 3'b000);
    checkOutput("midreset_busy", busy, 0);
    stale = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    checkOutput("midreset_no_stale_result", stale, 0);
    runVector("after_reset", 16'h0000, 16'hFFFF, 3'b100, ref_latency(16'h0000, 16'hFFFF));

    $display("[TB] streaming");
    for (int i = 0; i < 4; i++) begin
      pa[i] = WIDTH'($urandom);
      pb[i] = WIDTH'($urandom);
    end
    sent      = 0;
    recv      = 0;
    cyc       = 0;
    last_acc  = -1;
    a         = pa[0];
    b         = pb[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (recv < 4 && cyc < 500) begin
      accepted = 1'b0;
      if (in_valid && in_ready) begin
        if (last_acc >= 0) begin
          checkOutput("stream_spacing", cyc - last_acc, ref_latency(pa[sent-1], pb[sent-1]) + 2);
        end
        last_acc = cyc;
        expq.push_back(ref_gle(pa[sent], pb[sent]));
        sent++;
        accepted = 1'b1;
      end
      if (out_valid) begin
        expv = (expq.size() > 0) ? expq.pop_front() : 3'b000;
        checkOutput("stream_result", {g, l, e}, expv);
        recv++;
      end
      @(posedge clk); #1;
      cyc++;
      if (accepted) begin
        if (sent < 4) begin
          a = pa[sent];
          b = pb[sent];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checkOutput("stream_sent", sent, 4);
    checkOutput("stream_received", recv, 4);
    stale = 0;
    repeat (2 * WIDTH + 4) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    checkOutput("stream_no_duplicate", stale, 0);
    checkOutput("stream_queue_drained", expq.size(), 0);
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
